// File: rtl/inst_dec.sv
// inst_dec: RISC-V ID stage. It decodes register fields and the immediate, reads two operands, and registers the ID/EX word.
// Latency: 1 cycle from i_if_id_reg to o_id_ex_reg. The register file write is visible on the same cycle through the bypass.
// Backpressure: none. There is no stall or flush, and the ID/EX register loads on every rising edge while out of reset.
//
// Ports:
//   i_clk        rising-edge clock for all state
//   i_rst        asynchronous active-low reset; clears the ID/EX word and every register
//   i_if_id_reg  {PC[63:0], instruction[31:0]}
//   i_wr_reg     write-back destination register
//   i_wr_data    write-back data
//   i_reg_wr     write-back enable
//   o_id_ex_reg  {PC, rs1 data, rs2 data, imm, rd}

// inst_dec_regfile: 32-entry register file with two combinational read ports and one write port.
// Latency: reads are combinational, and a write lands on the rising edge. A same-cycle write is forwarded to the readers.
// Backpressure: none.
module inst_dec_regfile #(
    parameter int WORD_SIZE     = 32,
    parameter int REG_ADDR_SIZE = 5
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [REG_ADDR_SIZE-1:0] wr_addr,
    input  logic [WORD_SIZE-1:0]     wr_data,
    input  logic                     wr_en,
    input  logic [REG_ADDR_SIZE-1:0] rd_addr_a,
    input  logic [REG_ADDR_SIZE-1:0] rd_addr_b,
    output logic [WORD_SIZE-1:0]     rd_data_a,
    output logic [WORD_SIZE-1:0]     rd_data_b
);
    localparam int NUM_REGS = 1 << REG_ADDR_SIZE;

    logic [WORD_SIZE-1:0] mem [0:NUM_REGS-1];
    logic                 wr_active;

    // x0 is hardwired to zero, so writes aimed at it are dropped here.
    assign wr_active = wr_en && (wr_addr != '0);

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_active) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Write-through forwarding lets WB and ID share a cycle without a hazard.
    always_comb begin
        rd_data_a = '0;
        if (rd_addr_a == '0) begin
            rd_data_a = '0;
        end else if (wr_active && (wr_addr == rd_addr_a)) begin
            rd_data_a = wr_data;
        end else begin
            rd_data_a = mem[rd_addr_a];
        end
    end

    always_comb begin
        rd_data_b = '0;
        if (rd_addr_b == '0) begin
            rd_data_b = '0;
        end else if (wr_active && (wr_addr == rd_addr_b)) begin
            rd_data_b = wr_data;
        end else begin
            rd_data_b = mem[rd_addr_b];
        end
    end
endmodule

module inst_dec #(
    parameter int WORD_SIZE     = 32,
    parameter int PC_SIZE       = 64,
    parameter int REG_ADDR_SIZE = 5
) (
    input  logic                                          i_clk,
    input  logic                                          i_rst,
    input  logic [PC_SIZE+WORD_SIZE-1:0]                  i_if_id_reg,
    input  logic [REG_ADDR_SIZE-1:0]                      i_wr_reg,
    input  logic [WORD_SIZE-1:0]                          i_wr_data,
    input  logic                                          i_reg_wr,
    output logic [2*PC_SIZE+2*WORD_SIZE+REG_ADDR_SIZE-1:0] o_id_ex_reg
);
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    logic [PC_SIZE-1:0]       pc;
    logic [WORD_SIZE-1:0]     inst;
    logic [6:0]               opcode;
    logic [REG_ADDR_SIZE-1:0] rs1;
    logic [REG_ADDR_SIZE-1:0] rs2;
    logic [REG_ADDR_SIZE-1:0] rd;
    logic [WORD_SIZE-1:0]     rd1;
    logic [WORD_SIZE-1:0]     rd2;
    logic [PC_SIZE-1:0]       imm;
    logic                     unused_funct3;

    assign pc     = i_if_id_reg[PC_SIZE+WORD_SIZE-1 -: PC_SIZE];
    assign inst   = i_if_id_reg[WORD_SIZE-1:0];
    assign opcode = inst[6:0];
    assign rs1    = inst[19:15];
    assign rs2    = inst[24:20];
    assign rd     = inst[11:7];

    // funct3 only matters to later stages, so it is not decoded here.
    assign unused_funct3 = ^inst[14:12];

    inst_dec_regfile #(
        .WORD_SIZE     (WORD_SIZE),
        .REG_ADDR_SIZE (REG_ADDR_SIZE)
    ) register_file (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .wr_addr   (i_wr_reg),
        .wr_data   (i_wr_data),
        .wr_en     (i_reg_wr),
        .rd_addr_a (rs1),
        .rd_addr_b (rs2),
        .rd_data_a (rd1),
        .rd_data_b (rd2)
    );

    // Immediate formats. The top instruction bit always carries the sign.
    always_comb begin
        imm = '0;
        case (opcode)
            OP_LOAD, OP_IMM, OP_IMM32, OP_JALR, OP_SYSTEM:
                imm = {{(PC_SIZE-12){inst[31]}}, inst[31:20]};
            OP_STORE:
                imm = {{(PC_SIZE-12){inst[31]}}, inst[31:25], inst[11:7]};
            OP_BRANCH:
                imm = {{(PC_SIZE-13){inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            OP_LUI, OP_AUIPC:
                imm = {{(PC_SIZE-32){inst[31]}}, inst[31:12], 12'b0};
            OP_JAL:
                imm = {{(PC_SIZE-21){inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default:
                imm = '0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_id_ex_reg <= '0;
        end else begin
            o_id_ex_reg <= {pc, rd1, rd2, imm, rd};
        end
    end
endmodule

// File: tb/tb_inst_dec.sv
module tb_inst_dec;
    logic         i_clk;
    logic         i_rst;
    logic [95:0]  i_if_id_reg;
    logic [4:0]   i_wr_reg;
    logic [31:0]  i_wr_data;
    logic         i_reg_wr;
    logic [196:0] o_id_ex_reg;
    logic         clk_en;

    int n_pass;
    int n_total;

    // Architectural view of the register file. Index 0 is never written.
    logic [31:0] mregs [32];

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [31:0] e_rd1;
        logic [31:0] e_rd2;
        logic [63:0] e_imm;
        logic [4:0]  e_rd;
    } vec_t;

    vec_t vecs [10];
    logic [6:0] ops [12];

    inst_dec dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_if_id_reg (i_if_id_reg),
        .i_wr_reg    (i_wr_reg),
        .i_wr_data   (i_wr_data),
        .i_reg_wr    (i_reg_wr),
        .o_id_ex_reg (o_id_ex_reg)
    );

    initial i_clk = 1'b0;
    always #5 if (clk_en) i_clk = ~i_clk;

    task automatic check(input string nm, input logic [196:0] act, input logic [196:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic logic regs_nonzero();
        logic any;
        any = 1'b0;
        for (int i = 1; i < 32; i++) if (dut.register_file.mem[i] != 32'd0) any = 1'b1;
        return any;
    endfunction

    // Immediate from the format rules, using signed values and arithmetic scaling.
    function automatic logic [63:0] ref_imm(input logic [31:0] inst);
        logic signed [63:0] v;
        case (inst[6:0])
            7'b0000011, 7'b0010011, 7'b0011011, 7'b1100111, 7'b1110011:
                v = 64'($signed(inst[31:20]));
            7'b0100011: v = 64'($signed({inst[31:25], inst[11:7]}));
            7'b1100011: v = 64'($signed({inst[31], inst[7], inst[30:25], inst[11:8]})) * 2;
            7'b0110111, 7'b0010111: v = 64'($signed(inst[31:12])) * 4096;
            7'b1101111: v = 64'($signed({inst[31], inst[19:12], inst[20], inst[30:21]})) * 2;
            default: v = 64'sd0;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] ref_read(input logic [4:0] a, input logic we,
                                             input logic [4:0] wa, input logic [31:0] wd);
        if (a == 5'd0) return 32'd0;
        if (we && wa == a) return wd;
        return mregs[a];
    endfunction

    function automatic logic [196:0] ref_word(input logic [63:0] pc, input logic [31:0] inst,
                                              input logic we, input logic [4:0] wa, input logic [31:0] wd);
        return {pc, ref_read(inst[19:15], we, wa, wd), ref_read(inst[24:20], we, wa, wd),
                ref_imm(inst), inst[11:7]};
    endfunction

    // Apply one set of inputs across a rising edge, compare, then commit the write to the model.
    task automatic cycle(input string nm, input logic [63:0] pc, input logic [31:0] inst,
                         input logic we, input logic [4:0] wa, input logic [31:0] wd);
        logic [196:0] exp;
        i_if_id_reg = {pc, inst};
        i_reg_wr    = we;
        i_wr_reg    = wa;
        i_wr_data   = wd;
        exp = ref_word(pc, inst, we, wa, wd);
        @(posedge i_clk);
        #1;
        check(nm, o_id_ex_reg, exp);
        if (we && wa != 5'd0) mregs[wa] = wd;
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        clk_en = 1'b0;
        for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
        ops = '{7'b0000011, 7'b0010011, 7'b0011011, 7'b1100111, 7'b1110011, 7'b0100011,
                7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b0110011, 7'b0111011};

        //        pc        inst          we   wa     wd         rd1         rd2         imm                     rd
        vecs[0] = '{64'h0,   32'h00000000, 1'b0, 5'd0,  32'h0,      32'h0,      32'h0,      64'h0,                  5'd0};
        vecs[1] = '{64'h0,   32'h00000000, 1'b1, 5'd5,  32'h45,     32'h0,      32'h0,      64'h0,                  5'd0};
        vecs[2] = '{64'h100, 32'hFFF28193, 1'b0, 5'd0,  32'h0,      32'h45,     32'h0,      64'hFFFFFFFFFFFFFFFF,   5'd3};
        vecs[3] = '{64'h104, 32'h00000013, 1'b1, 5'd0,  32'hDEAD,   32'h0,      32'h0,      64'h0,                  5'd0};
        vecs[4] = '{64'h108, 32'h00000013, 1'b0, 5'd0,  32'h0,      32'h0,      32'h0,      64'h0,                  5'd0};
        vecs[5] = '{64'h10C, 32'h007380B3, 1'b1, 5'd7,  32'h1234,   32'h1234,   32'h1234,   64'h0,                  5'd1};
        vecs[6] = '{64'h110, 32'h0020B423, 1'b1, 5'd1,  32'h11,     32'h11,     32'h0,      64'h8,                  5'd8};
        vecs[7] = '{64'h114, 32'hFE000EE3, 1'b0, 5'd0,  32'h0,      32'h0,      32'h0,      64'hFFFFFFFFFFFFFFFC,   5'd29};
        vecs[8] = '{64'h118, 32'h12345037, 1'b1, 5'd10, 32'hA0A0,   32'h0,      32'h0,      64'h0000000012345000,   5'd0};
        vecs[9] = '{64'h11C, 32'h00B50533, 1'b0, 5'd0,  32'h0,      32'hA0A0,   32'h0,      64'h0,                  5'd10};

        // Reset with the clock stopped and a write pending.
        i_rst = 1'b0;
        i_if_id_reg = {32'hDEADBEEF, 32'h12345678, 32'hFFF28193};
        i_reg_wr = 1'b1;
        i_wr_reg = 5'd9;
        i_wr_data = 32'hCAFEF00D;
        #20;
        check("reset_out_noclk", o_id_ex_reg, 197'd0);
        check("reset_mem_noclk", {196'd0, regs_nonzero()}, 197'd0);

        // Reset held while the clock runs must block the pending write.
        clk_en = 1'b1;
        repeat (3) @(posedge i_clk);
        #1;
        check("reset_out_held", o_id_ex_reg, 197'd0);
        check("reset_mem_held", {196'd0, regs_nonzero()}, 197'd0);
        #3;
        i_if_id_reg = '0;
        i_reg_wr = 1'b0;
        i_wr_reg = '0;
        i_wr_data = '0;
        i_rst = 1'b1;

        // Directed vectors. The model and the table carry state from row to row.
        for (int i = 0; i < 10; i++) begin
            logic [196:0] got;
            i_if_id_reg = {vecs[i].pc, vecs[i].inst};
            i_reg_wr = vecs[i].we;
            i_wr_reg = vecs[i].wa;
            i_wr_data = vecs[i].wd;
            @(posedge i_clk);
            #1;
            got = o_id_ex_reg;
            check($sformatf("vec%0d", i), got,
                  {vecs[i].pc, vecs[i].e_rd1, vecs[i].e_rd2, vecs[i].e_imm, vecs[i].e_rd});
            if (vecs[i].we && vecs[i].wa != 5'd0) mregs[vecs[i].wa] = vecs[i].wd;
        end
        check("x0_never_stored", {165'd0, dut.register_file.mem[0]}, 197'd0);

        // Randomized traffic checked against the model.
        for (int n = 0; n < 300; n++) begin
            logic [31:0] inst;
            int pick;
            inst = $urandom;
            pick = $urandom_range(0, 12);
            if (pick < 12) inst[6:0] = ops[pick];
            cycle($sformatf("rand%0d", n), {$urandom, $urandom}, inst,
                  1'($urandom_range(0, 1)), 5'($urandom), $urandom);
        end

        // Asynchronous reset asserted between edges in the middle of traffic.
        for (int n = 0; n < 5; n++)
            cycle($sformatf("pre_rst%0d", n), {$urandom, $urandom}, $urandom, 1'b1, 5'($urandom_range(1, 31)), $urandom);
        #2;
        i_rst = 1'b0;
        #1;
        check("midrst_out", o_id_ex_reg, 197'd0);
        check("midrst_mem", {196'd0, regs_nonzero()}, 197'd0);
        for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
        #3;
        i_rst = 1'b1;

        // The first edge after release captures normally. Preload x[k] = k + 64.
        for (int k = 1; k < 32; k++)
            cycle($sformatf("preload%0d", k), 64'(k), 32'h00000013, 1'b1, 5'(k), 32'(k + 64));
        for (int n = 0; n < 40; n++) begin
            logic [31:0] inst;
            inst = $urandom;
            inst[6:0] = 7'b0110011;
            cycle($sformatf("postrst%0d", n), {$urandom, $urandom}, inst, 1'b0, 5'd0, 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
